alu_ctrl_seq: RTL and testbench
===============================

// Module: alu_ctrl_seq
// PURPOSE
//  Drives the ALU's 4-bit alu_control input and consumes its zero output. It is the control-side
//  end of the ALU interface in the single-cycle/multicycle datapath.
//  Accepts one decoded instruction field pair (opcode, funct) per handshake and registers the
//  ALU operation code. For BEQ/BNE it samples ALU zero one cycle later and reports the branch decision.
//  Also keeps issue and illegal-instruction counters for the debug/perf path.
// PARAMETERS
//  CNT_W         16       width of issue_count and illegal_count (saturating)
//  ILLEGAL_CTRL  4'b0000  alu_control driven for an illegal opcode/funct
// PORTS
//  clk            in   1      single clock, rising edge
//  reset          in   1      asynchronous, active-high reset
//  in_valid       in   1      opcode/funct valid this cycle
//  in_ready       out  1      block can accept; transfer = in_valid & in_ready
//  opcode         in   6      instr[31:26]
//  funct          in   6      instr[5:0], used only when opcode==6'h00
//  alu_control    out  4      registered ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
//  zero           in   1      ALU zero flag, combinational from alu_control/operands
//  ctrl_valid     out  1      1-cycle pulse: alu_control is new this cycle
//  illegal        out  1      1-cycle pulse with ctrl_valid when the decode was illegal
//  br_valid       out  1      1-cycle pulse: branch decision available
//  br_taken       out  1      branch outcome, qualified by br_valid
//  issue_count    out  CNT_W  number of accepted instructions
//  illegal_count  out  CNT_W  number of illegal instructions
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, in_ready=1, alu_control=4'b0000, ctrl_valid=0, illegal=0,
//   br_valid=0, br_taken=0, both counters=0. Reset mid-operation abandons any pending branch; no br_valid follows.
//  FSM states: IDLE, ISSUE, RESOLVE. in_ready = (state==IDLE), combinational from state.
//   IDLE: on transfer, latch the decode into alu_control, latch is_branch/is_bne, go to ISSUE; otherwise stay.
//   ISSUE: ctrl_valid=1 (and illegal if the decode was illegal). If is_branch, go to RESOLVE and register
//    br_taken <= zero ^ is_bne at the end of this cycle. Otherwise go to IDLE.
//   RESOLVE: br_valid=1, go to IDLE.
//  Latency: transfer at cycle N -> ctrl_valid at N+1 -> br_valid at N+2.
//   Throughput is 1 instruction per 2 cycles (non-branch) or per 3 cycles (branch).
//  alu_control holds its value after ISSUE until the next transfer, so the ALU result stays stable.
//  Decode, R-type (opcode 00): funct 20 ADD, 22 SUB, 24 AND, 25 OR, 27 NOR, 2A SLT; any other funct is illegal.
//  Decode, I-type: 23 LW and 2B SW -> ADD; 04 BEQ and 05 BNE -> SUB (branch); 08 ADDI -> ADD;
//   0C ANDI -> AND; 0D ORI -> OR; 0A SLTI -> SLT; any other opcode is illegal.
//  Illegal decode: alu_control=ILLEGAL_CTRL, illegal pulses in ISSUE, never treated as a branch.
//  in_valid while in_ready=0 is ignored; the upstream stage must hold the instruction.
//  Only zero sampled in ISSUE is used; zero in any other cycle has no effect.
//  issue_count increments on every transfer. illegal_count increments in ISSUE when illegal=1.
//  Both counters saturate at all-ones and do not wrap.
// TESTING
//  1. Reset asserted mid-ISSUE of a BEQ: outputs go to reset values immediately;
//     no br_valid after release; in_ready=1.
//  2. opcode 00, funct 22 at cycle N: in_ready drops at N+1, alu_control=0110 and ctrl_valid=1 at N+1,
//     in_ready=1 at N+2, issue_count=1.
//  3. BEQ (opcode 04) with zero=1 in ISSUE -> br_valid=1, br_taken=1 at N+2.
//     BNE (opcode 05) with zero=1 -> br_taken=0.
//  4. opcode 00, funct 3F -> alu_control=ILLEGAL_CTRL, illegal=1 with ctrl_valid, illegal_count=1, no br_valid.
//  5. Back-to-back in_valid=1 held for 10 cycles with LW (23) -> exactly 5 transfers,
//     alu_control=0010 each time, issue_count=5.
//  6. CNT_W=2: 5 accepted instructions -> issue_count saturates at 3 and does not wrap to 0.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: decodes opcode/funct into alu_control, pulses ctrl_valid,
// resolves BEQ/BNE from the ALU zero flag, and keeps saturating issue/illegal counters.
module alu_ctrl_seq #(
    parameter int unsigned CNT_W        = 16,
    parameter logic [3:0]  ILLEGAL_CTRL = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    output logic [3:0]       alu_control,
    input  logic             zero,
    output logic             ctrl_valid,
    output logic             illegal,
    output logic             br_valid,
    output logic             br_taken,
    output logic [CNT_W-1:0] issue_count,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t     state;
    logic       is_branch;
    logic       is_bne;
    logic [3:0] dec_ctrl;
    logic       dec_illegal;
    logic       dec_branch;
    logic       dec_bne;
    logic       transfer;

    assign in_ready = (state == IDLE);
    assign transfer = in_valid & in_ready;

    // Instruction field decode; anything unrecognised falls through to the illegal defaults.
    always_comb begin
        dec_ctrl    = ILLEGAL_CTRL;
        dec_illegal = 1'b1;
        dec_branch  = 1'b0;
        dec_bne     = 1'b0;
        case (opcode)
            6'h00: begin
                dec_illegal = 1'b0;
                case (funct)
                    6'h20:   dec_ctrl = CTRL_ADD;
                    6'h22:   dec_ctrl = CTRL_SUB;
                    6'h24:   dec_ctrl = CTRL_AND;
                    6'h25:   dec_ctrl = CTRL_OR;
                    6'h27:   dec_ctrl = CTRL_NOR;
                    6'h2A:   dec_ctrl = CTRL_SLT;
                    default: dec_illegal = 1'b1;
                endcase
            end
            6'h23, 6'h2B, 6'h08: begin
                dec_ctrl    = CTRL_ADD;
                dec_illegal = 1'b0;
            end
            6'h04, 6'h05: begin
                dec_ctrl    = CTRL_SUB;
                dec_illegal = 1'b0;
                dec_branch  = 1'b1;
                dec_bne     = opcode[0];
            end
            6'h0C: begin
                dec_ctrl    = CTRL_AND;
                dec_illegal = 1'b0;
            end
            6'h0D: begin
                dec_ctrl    = CTRL_OR;
                dec_illegal = 1'b0;
            end
            6'h0A: begin
                dec_ctrl    = CTRL_SLT;
                dec_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    // Sequencer FSM with registered outputs and saturating counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            alu_control   <= 4'b0000;
            ctrl_valid    <= 1'b0;
            illegal       <= 1'b0;
            br_valid      <= 1'b0;
            br_taken      <= 1'b0;
            is_branch     <= 1'b0;
            is_bne        <= 1'b0;
            issue_count   <= '0;
            illegal_count <= '0;
        end else begin
            ctrl_valid <= 1'b0;
            illegal    <= 1'b0;
            br_valid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (transfer) begin
                        state       <= ISSUE;
                        alu_control <= dec_ctrl;
                        ctrl_valid  <= 1'b1;
                        illegal     <= dec_illegal;
                        is_branch   <= dec_branch & ~dec_illegal;
                        is_bne      <= dec_bne;
                        if (issue_count != '1) begin
                            issue_count <= issue_count + CNT_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (illegal && (illegal_count != '1)) begin
                        illegal_count <= illegal_count + CNT_W'(1);
                    end
                    if (is_branch) begin
                        state    <= RESOLVE;
                        br_valid <= 1'b1;
                        br_taken <= zero ^ is_bne;
                    end else begin
                        state <= IDLE;
                    end
                end
                RESOLVE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq; a second CNT_W=2 instance checks saturation.
module tb_alu_ctrl_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic        zero = 1'b0;

    logic        in_ready, ctrl_valid, illegal, br_valid, br_taken;
    logic [3:0]  alu_control;
    logic [15:0] issue_count, illegal_count;

    logic        s_in_ready, s_ctrl_valid, s_illegal, s_br_valid, s_br_taken;
    logic [3:0]  s_alu_control;
    logic [1:0]  s_issue_count, s_illegal_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_issue = 0;
    int exp_illegal = 0;

    always #5 clk = ~clk;

    alu_ctrl_seq #(.CNT_W(16), .ILLEGAL_CTRL(4'b0000)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .alu_control(alu_control), .zero(zero),
        .ctrl_valid(ctrl_valid), .illegal(illegal), .br_valid(br_valid), .br_taken(br_taken),
        .issue_count(issue_count), .illegal_count(illegal_count)
    );

    alu_ctrl_seq #(.CNT_W(2), .ILLEGAL_CTRL(4'b0000)) dut_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .opcode(opcode), .funct(funct), .alu_control(s_alu_control), .zero(zero),
        .ctrl_valid(s_ctrl_valid), .illegal(s_illegal), .br_valid(s_br_valid), .br_taken(s_br_taken),
        .issue_count(s_issue_count), .illegal_count(s_illegal_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({in_ready, ctrl_valid, illegal, br_valid, br_taken, alu_control} !== {1'b1, 4'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b cv=%b ill=%b bv=%b bt=%b ctrl=%h, expected rdy=1 others 0",
                     in_ready, ctrl_valid, illegal, br_valid, br_taken, alu_control);
        end
        n_checks++;
        if (issue_count !== 16'd0 || illegal_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got issue=%0d illegal=%0d, expected 0 0", issue_count, illegal_count);
        end
        reset = 1'b0;
        exp_issue = 0;
        exp_illegal = 0;
        tick();
    endtask

    task automatic test_rtype_sub();
        opcode = 6'h00; funct = 6'h22; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_issue++;
        n_checks++;
        if ({in_ready, ctrl_valid, illegal, alu_control} !== {1'b0, 1'b1, 1'b0, 4'b0110}) begin
            n_fail++;
            $display("FAIL sub_issue: got rdy=%b cv=%b ill=%b ctrl=%b, expected rdy=0 cv=1 ill=0 ctrl=0110",
                     in_ready, ctrl_valid, illegal, alu_control);
        end
        tick();
        n_checks++;
        if ({in_ready, ctrl_valid, br_valid, alu_control} !== {1'b1, 1'b0, 1'b0, 4'b0110}) begin
            n_fail++;
            $display("FAIL sub_after: got rdy=%b cv=%b bv=%b ctrl=%b, expected rdy=1 cv=0 bv=0 ctrl=0110",
                     in_ready, ctrl_valid, br_valid, alu_control);
        end
        n_checks++;
        if (issue_count !== 16'(exp_issue)) begin
            n_fail++;
            $display("FAIL sub_issue_count: got %0d expected %0d", issue_count, exp_issue);
        end
    endtask

    task automatic test_decode();
        logic [5:0] ops [12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h3F};
        logic [5:0] fns [12] = '{6'h20, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h22, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20};
        logic [3:0] exp [12] = '{4'h2, 4'h0, 4'h1, 4'hC, 4'h7, 4'h2, 4'h2, 4'h2, 4'h0, 4'h1, 4'h7, 4'h0};
        logic       eil [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            opcode = ops[i]; funct = fns[i]; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            exp_issue++;
            if (eil[i]) exp_illegal++;
            n_checks++;
            if ({ctrl_valid, illegal, alu_control} !== {1'b1, eil[i], exp[i]}) begin
                n_fail++;
                $display("FAIL decode_%0d op=%h fn=%h: got cv=%b ill=%b ctrl=%b, expected cv=1 ill=%b ctrl=%b",
                         i, ops[i], fns[i], ctrl_valid, illegal, alu_control, eil[i], exp[i]);
            end
            tick();
            n_checks++;
            if ({in_ready, br_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL decode_done_%0d: got rdy=%b bv=%b, expected rdy=1 bv=0", i, in_ready, br_valid);
            end
        end
        n_checks++;
        if (issue_count !== 16'(exp_issue) || illegal_count !== 16'(exp_illegal)) begin
            n_fail++;
            $display("FAIL decode_counts: got issue=%0d illegal=%0d, expected %0d %0d",
                     issue_count, illegal_count, exp_issue, exp_illegal);
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [4] = '{6'h04, 6'h05, 6'h04, 6'h05};
        logic       zis [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       etk [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            opcode = ops[i]; funct = 6'h2A; in_valid = 1'b1; zero = ~zis[i];
            tick();
            in_valid = 1'b0;
            exp_issue++;
            zero = zis[i];
            n_checks++;
            if ({ctrl_valid, br_valid, alu_control} !== {1'b1, 1'b0, 4'b0110}) begin
                n_fail++;
                $display("FAIL br_issue_%0d: got cv=%b bv=%b ctrl=%b, expected cv=1 bv=0 ctrl=0110",
                         i, ctrl_valid, br_valid, alu_control);
            end
            tick();
            zero = ~zis[i];
            n_checks++;
            if ({in_ready, ctrl_valid, br_valid, br_taken} !== {1'b0, 1'b0, 1'b1, etk[i]}) begin
                n_fail++;
                $display("FAIL br_resolve_%0d op=%h z=%b: got rdy=%b cv=%b bv=%b bt=%b, expected rdy=0 cv=0 bv=1 bt=%b",
                         i, ops[i], zis[i], in_ready, ctrl_valid, br_valid, br_taken, etk[i]);
            end
            tick();
            n_checks++;
            if ({in_ready, br_valid, br_taken} !== {1'b1, 1'b0, etk[i]}) begin
                n_fail++;
                $display("FAIL br_done_%0d: got rdy=%b bv=%b bt=%b, expected rdy=1 bv=0 bt=%b",
                         i, in_ready, br_valid, br_taken, etk[i]);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal();
        opcode = 6'h00; funct = 6'h3F; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_issue++;
        exp_illegal++;
        n_checks++;
        if ({ctrl_valid, illegal, alu_control} !== {1'b1, 1'b1, 4'b0000}) begin
            n_fail++;
            $display("FAIL illegal_issue: got cv=%b ill=%b ctrl=%b, expected cv=1 ill=1 ctrl=0000",
                     ctrl_valid, illegal, alu_control);
        end
        tick();
        n_checks++;
        if ({in_ready, illegal, br_valid} !== 3'b100 || illegal_count !== 16'(exp_illegal)) begin
            n_fail++;
            $display("FAIL illegal_after: got rdy=%b ill=%b bv=%b icnt=%0d, expected rdy=1 ill=0 bv=0 icnt=%0d",
                     in_ready, illegal, br_valid, illegal_count, exp_illegal);
        end
    endtask

    task automatic test_reset_mid_branch();
        int seen_bv = 0;
        opcode = 6'h04; funct = 6'h00; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        zero = 1'b1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, ctrl_valid, illegal, br_valid, br_taken, alu_control} !== {1'b1, 4'b0, 4'b0000}
            || issue_count !== 16'd0 || illegal_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got rdy=%b cv=%b bv=%b bt=%b ctrl=%b issue=%0d ill=%0d, expected rdy=1 rest 0",
                     in_ready, ctrl_valid, br_valid, br_taken, alu_control, issue_count, illegal_count);
        end
        #2;
        reset = 1'b0;
        exp_issue = 0;
        exp_illegal = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (br_valid) seen_bv++;
        end
        zero = 1'b0;
        n_checks++;
        if (seen_bv !== 0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_after: got br_valid pulses=%0d rdy=%b, expected 0 and rdy=1", seen_bv, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int bad_ctrl = 0;
        opcode = 6'h23; funct = 6'h00; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ctrl_valid) begin
                pulses++;
                if (alu_control !== 4'b0010) bad_ctrl++;
            end
        end
        in_valid = 1'b0;
        exp_issue += 5;
        tick();
        n_checks++;
        if (pulses !== 5 || bad_ctrl !== 0) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d pulses (%0d with wrong ctrl), expected 5 pulses all 0010",
                     pulses, bad_ctrl);
        end
        n_checks++;
        if (issue_count !== 16'(exp_issue)) begin
            n_fail++;
            $display("FAIL b2b_issue_count: got %0d expected %0d", issue_count, exp_issue);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_small [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        opcode = 6'h00; funct = 6'h20;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            n_checks++;
            if (s_issue_count !== exp_small[i]) begin
                n_fail++;
                $display("FAIL sat_step_%0d: got %0d expected %0d", i, s_issue_count, exp_small[i]);
            end
        end
        n_checks++;
        if (issue_count !== 16'd5) begin
            n_fail++;
            $display("FAIL sat_wide_count: got %0d expected 5", issue_count);
        end
    endtask

    initial begin
        test_reset();
        test_rtype_sub();
        test_decode();
        test_branch();
        test_illegal();
        test_reset_mid_branch();
        test_back_to_back();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
